// File: rtl/sound_play_ctrl.sv
// rtl/sound_play_ctrl.sv - single-clock playback sequencer feeding ROM samples to the PWM stage
//
// Purpose:
//   Walks the sample ROM from start_addr to end_addr (inclusive), fetching one
//   sample every DIV clock cycles.  Each fetched sample is registered and
//   presented to the PWM stage together with a one-cycle sample_vld strobe.
//   Playback can be started, aborted (stop) and held at a sample boundary
//   (pause).  All timing is derived from one tick counter; there are no
//   derived clocks.
//
// Ports:
//   clk, rstn              system clock, synchronous active-low reset
//   start, stop            one-cycle command pulses (stop wins over start)
//   pause                  level; holds playback at the next period boundary
//   start_addr, end_addr   playback range, captured when start is accepted
//   loop_cnt               extra passes over the range (SOUND_PLAY_LOOP_EN only)
//   rom_addr, rom_rd       ROM read request, one strobe per sample period
//   rom_data               ROM read data, valid RD_LAT cycles after rom_rd
//   sample, sample_vld     registered sample and its update strobe
//   aud_en, busy           PWM enable / sequencer active (RUN or PAUSE)
//   done                   one-cycle pulse when the final period completes
//
// Optional feature:
//   SOUND_PLAY_LOOP_EN     when defined, adds loop_cnt and seamless multi-pass
//                          playback; when undefined, playback is a single pass.
//
// Parameters: AW address width, DW sample width, DIV sample period in cycles
// (must be >= RD_LAT+2), RD_LAT ROM read latency in cycles.

module sound_play_ctrl #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int DIV    = 1024,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
`ifdef SOUND_PLAY_LOOP_EN
  input  logic [7:0]    loop_cnt,
`endif
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] sample,
  output logic          sample_vld,
  output logic          aud_en,
  output logic          busy,
  output logic          done
);

  localparam int TW = (DIV > 2) ? $clog2(DIV) : 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // Tick positions inside one sample period.
  localparam logic [TW-1:0] TICK_FETCH   = '0;
  localparam logic [TW-1:0] TICK_CAPTURE = TW'(RD_LAT);
  localparam logic [TW-1:0] TICK_LAST    = TW'(DIV - 1);

  logic [1:0]    state_q,      state_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic [AW-1:0] end_addr_q,   end_addr_d;
  logic [TW-1:0] tick_q,       tick_d;
  logic [DW-1:0] sample_q,     sample_d;
  logic          sample_vld_q, sample_vld_d;
  logic          done_q,       done_d;

`ifdef SOUND_PLAY_LOOP_EN
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic [7:0]    loops_left_q, loops_left_d;
`endif

  logic start_ok;
  logic range_end;

  // A start arriving in the same cycle as the done pulse still belongs to the
  // playback that just finished, so it is dropped along with any start seen
  // while busy.  An empty (reversed) range is silently ignored.
  assign start_ok  = start && !stop && !done_q && (start_addr <= end_addr);
  assign range_end = (addr_q == end_addr_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    end_addr_d   = end_addr_q;
    tick_d       = tick_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    done_d       = 1'b0;
`ifdef SOUND_PLAY_LOOP_EN
    start_addr_d = start_addr_q;
    loops_left_d = loops_left_q;
`endif

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (start_ok) begin
          state_d    = S_RUN;
          addr_d     = start_addr;
          end_addr_d = end_addr;
`ifdef SOUND_PLAY_LOOP_EN
          start_addr_d = start_addr;
          loops_left_d = loop_cnt;
`endif
        end
      end

      S_RUN: begin
        if (stop) begin
          // Abort: the PWM stage must go silent, so the sample is cleared
          // rather than held, and no done pulse is produced.
          state_d  = S_IDLE;
          tick_d   = '0;
          sample_d = '0;
        end else begin
          if (tick_q == TICK_CAPTURE) begin
            sample_d     = rom_data;
            sample_vld_d = 1'b1;
          end

          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (range_end) begin
`ifdef SOUND_PLAY_LOOP_EN
              if (loops_left_q != 8'd0) begin
                // Rewind without a gap; the next period fetches start_addr.
                loops_left_d = loops_left_q - 8'd1;
                addr_d       = start_addr_q;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
`else
              state_d = S_IDLE;
              done_d  = 1'b1;
`endif
            end else if (pause) begin
              // Address advances now so that leaving PAUSE fetches the
              // next sample immediately.
              addr_d  = addr_q + AW'(1);
              state_d = S_PAUSE;
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      S_PAUSE: begin
        tick_d = '0;
        if (stop) begin
          state_d  = S_IDLE;
          sample_d = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      end_addr_q   <= '0;
      tick_q       <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef SOUND_PLAY_LOOP_EN
      start_addr_q <= '0;
      loops_left_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      end_addr_q   <= end_addr_d;
      tick_q       <= tick_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      done_q       <= done_d;
`ifdef SOUND_PLAY_LOOP_EN
      start_addr_q <= start_addr_d;
      loops_left_q <= loops_left_d;
`endif
    end
  end

  // The read strobe is a pure decode of the schedule, so a reset or stop
  // removes it on the same edge and any in-flight read is simply never
  // captured.
  assign rom_rd     = (state_q == S_RUN) && (tick_q == TICK_FETCH);
  assign rom_addr   = addr_q;
  assign sample     = sample_q;
  assign sample_vld = sample_vld_q;
  assign busy       = (state_q != S_IDLE);
  assign aud_en     = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_sound_play_ctrl.sv
// tb/tb_sound_play_ctrl.sv - directed self-checking bench for sound_play_ctrl

module tb_sound_play_ctrl;

  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int DIV    = 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, stop, pause;
  logic [AW-1:0] start_addr, end_addr;
`ifdef SOUND_PLAY_LOOP_EN
  logic [7:0]    loop_cnt;
`endif
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] sample;
  logic          sample_vld, aud_en, busy, done;

  sound_play_ctrl #(.AW(AW), .DW(DW), .DIV(DIV), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .start_addr (start_addr),
    .end_addr   (end_addr),
`ifdef SOUND_PLAY_LOOP_EN
    .loop_cnt   (loop_cnt),
`endif
    .rom_addr   (rom_addr),
    .rom_rd     (rom_rd),
    .rom_data   (rom_data),
    .sample     (sample),
    .sample_vld (sample_vld),
    .aud_en     (aud_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ROM returns the address as data, one cycle after the strobe; anything
  // else reads as garbage so a mistimed capture is visible.
  always @(posedge clk) rom_data <= rom_rd ? {24'h0, rom_addr} : 32'hDEAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic [AW-1:0] rd_addrs[$];
  int           rd_cycs[$];
  always @(negedge clk) begin
    if (rom_rd) begin
      rd_addrs.push_back(rom_addr);
      rd_cycs.push_back(cyc);
      rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int vec_cnt = 0;
  int miscmp  = 0;

  typedef struct {
    int            pre;
    logic          st, sp, pa;
    logic [AW-1:0] sa, ea;
    logic          rd;
    logic [AW-1:0] addr;
    logic          vld;
    logic [DW-1:0] smp;
    logic          bsy, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int pre, int st, int sp, int pa, int sa, int ea,
                              int rd, int addr, int vld, int smp, int bsy, int dn);
    vec_t v;
    v.pre = pre;        v.st = st[0];        v.sp = sp[0];      v.pa = pa[0];
    v.sa = AW'(sa);     v.ea = AW'(ea);      v.rd = rd[0];      v.addr = AW'(addr);
    v.vld = vld[0];     v.smp = DW'(smp);    v.bsy = bsy[0];    v.dn = dn[0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic start_run(input int sa, input int ea);
    start_addr = AW'(sa); end_addr = AW'(ea); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit row_ok;
    int n_rd, n_dn;

    rstn = 1'b0; idle_in(); start_addr = '0; end_addr = '0;
`ifdef SOUND_PLAY_LOOP_EN
    loop_cnt = 8'd0;
`endif

    // Stimulus table: pre = idle cycles before the row; the row's inputs are
    // applied in the cycle whose outputs it checks.  rom_addr is checked only
    // on rows expecting rom_rd.
    // basic playback 4..6
    tbl.push_back(mk(0, 1,0,0, 4,6,   0,0,   0,0,   0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   1,4,   0,0,   1,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,0,   1,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   1,4,   1,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,4,   1,0));
    tbl.push_back(mk(4, 0,0,0, 0,0,   1,5,   0,4,   1,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,   0,0,   1,5,   1,0));
    tbl.push_back(mk(5, 0,0,0, 0,0,   1,6,   0,5,   1,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,   0,0,   1,6,   1,0));
    tbl.push_back(mk(4, 0,0,0, 0,0,   0,0,   0,6,   1,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,6,   0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,6,   0,0));
    // single sample 9..9
    tbl.push_back(mk(0, 1,0,0, 9,9,   0,0,   0,6,   0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   1,9,   0,6,   1,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,   0,0,   1,9,   1,0));
    tbl.push_back(mk(5, 0,0,0, 0,0,   0,0,   0,9,   0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,9,   0,0));
    // reversed range 7..3 is ignored
    tbl.push_back(mk(0, 1,0,0, 7,3,   0,0,   0,9,   0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,9,   0,0));
    tbl.push_back(mk(8, 0,0,0, 0,0,   0,0,   0,9,   0,0));
    // stop during addr 5
    tbl.push_back(mk(0, 1,0,0, 4,6,   0,0,   0,9,   0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   1,4,   0,9,   1,0));
    tbl.push_back(mk(7, 0,0,0, 0,0,   1,5,   0,4,   1,0));
    tbl.push_back(mk(2, 0,1,0, 0,0,   0,0,   0,5,   1,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,0,   0,0));
    tbl.push_back(mk(14,0,0,0, 0,0,   0,0,   0,0,   0,0));
    // start+stop together in IDLE
    tbl.push_back(mk(0, 1,1,0, 1,2,   0,0,   0,0,   0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,0,   0,0));
    // top-of-address-space range 254..255
    tbl.push_back(mk(0, 1,0,0, 254,255, 0,0, 0,0,   0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,   1,254, 0,0,   1,0));
    tbl.push_back(mk(7, 0,0,0, 0,0,   1,255, 0,254, 1,0));
    tbl.push_back(mk(7, 0,0,0, 0,0,   0,0,   0,255, 0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,   0,0,   0,255, 0,0));

    @(negedge clk);
    repeat (3) tick();
    chk("reset_outputs",
        {rom_addr, rom_rd, sample, sample_vld, aud_en, busy, done},
        {AW'(0), 1'b0, DW'(0), 1'b0, 1'b0, 1'b0, 1'b0});
    rstn = 1'b1;
    tick();

    for (int r = 0; r < tbl.size(); r++) begin
      repeat (tbl[r].pre) begin idle_in(); tick(); end
      vec_cnt++;
      row_ok = (rom_rd === tbl[r].rd) && (!tbl[r].rd || rom_addr === tbl[r].addr) &&
               (sample_vld === tbl[r].vld) && (sample === tbl[r].smp) &&
               (busy === tbl[r].bsy) && (aud_en === tbl[r].bsy) && (done === tbl[r].dn);
      if (!row_ok) begin
        miscmp++;
        $display("FAIL vec%0d: rd=%b addr=%0d vld=%b smp=%0h busy=%b aud=%b done=%b, want rd=%b addr=%0d vld=%b smp=%0h busy=%b done=%b",
                 r, rom_rd, rom_addr, sample_vld, sample, busy, aud_en, done,
                 tbl[r].rd, tbl[r].addr, tbl[r].vld, tbl[r].smp, tbl[r].bsy, tbl[r].dn);
      end
      start = tbl[r].st; stop = tbl[r].sp; pause = tbl[r].pa;
      start_addr = tbl[r].sa; end_addr = tbl[r].ea;
      tick();
      idle_in();
    end
    chk("table_rd_count", 64'(rd_cnt), 64'd8);
    chk("table_done_count", 64'(done_cnt), 64'd3);

    // Pause raised mid-period of addr 5, released later.
    start_run(4, 6);                 // now t+1
    repeat (11) tick();              // t+12, mid-period of addr 5
    pause = 1'b1;
    repeat (5) tick();               // t+17, first PAUSE cycle
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("pause_hold%0d", i), {rom_rd, sample, aud_en, busy},
          {1'b0, DW'(5), 1'b1, 1'b1});
      if (i < 5) tick();
    end
    pause = 1'b0;
    tick();
    chk("pause_resume_fetch", {rom_rd, rom_addr}, {1'b1, AW'(6)});
    wait_done(40, ok);
    chk("pause_done_seen", 64'(ok), 64'd1);
    tick();

    // Start while busy is ignored.
    rd_addrs.delete();
    n_dn = done_cnt;
    start_run(4, 6);
    repeat (3) tick();
    start_addr = AW'(10); end_addr = AW'(20); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, ok);
    chk("busy_done_seen", 64'(ok), 64'd1);
    tick();
    chk("busy_rd_seq",
        {32'(rd_addrs.size()), (rd_addrs.size() == 3) ? {rd_addrs[0], rd_addrs[1], rd_addrs[2]} : 24'hFFFFFF},
        {32'd3, AW'(4), AW'(5), AW'(6)});
    chk("busy_done_count", 64'(done_cnt - n_dn), 64'd1);

    // Reset mid-run.
    start_run(4, 6);
    repeat (10) tick();              // t+11, sample 5 just presented
    rstn = 1'b0;
    tick();
    chk("midrun_reset",
        {rom_addr, rom_rd, sample, sample_vld, aud_en, busy, done},
        {AW'(0), 1'b0, DW'(0), 1'b0, 1'b0, 1'b0, 1'b0});
    rstn = 1'b1;
    n_rd = rd_cnt; n_dn = done_cnt;
    repeat (20) tick();
    chk("post_reset_quiet", {32'(rd_cnt - n_rd), 31'(done_cnt - n_dn), busy},
        {32'd0, 31'd0, 1'b0});

`ifdef SOUND_PLAY_LOOP_EN
    // Two passes over 2..3 with no gap and a single done.
    rd_addrs.delete(); rd_cycs.delete();
    n_dn = done_cnt;
    loop_cnt = 8'd1;
    start_run(2, 3);
    loop_cnt = 8'd0;
    wait_done(60, ok);
    chk("loop_done_seen", 64'(ok), 64'd1);
    tick();
    chk("loop_rd_seq",
        {32'(rd_addrs.size()), (rd_addrs.size() == 4) ? {rd_addrs[0], rd_addrs[1], rd_addrs[2], rd_addrs[3]} : 32'hFFFFFFFF},
        {32'd4, AW'(2), AW'(3), AW'(2), AW'(3)});
    if (rd_cycs.size() == 4) begin
      chk("loop_spacing", {32'(rd_cycs[1] - rd_cycs[0]), 16'(rd_cycs[2] - rd_cycs[1]), 16'(rd_cycs[3] - rd_cycs[2])},
          {32'd8, 16'd8, 16'd8});
      chk("loop_done_timing", 64'(done_cyc - rd_cycs[3]), 64'd8);
    end
    chk("loop_done_count", 64'(done_cnt - n_dn), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/sound_play_ctrl.md
Name: sound_play_ctrl

Overview:
Playback sequencer for the audio sample path.
- On command, it fetches samples from the sample ROM over a range start_addr..end_addr, one sample per DIV clock cycles.
- It presents each sample, with a valid strobe and an enable, to the PWM stage.
- It replaces free-running address counting and derived clocks with a single-clock, enable-driven schedule that supports start, stop and pause.

Parameters:
AW, 16, ROM address width
DW, 32, sample width
DIV, 1024, sample period in clk cycles; legal range is DIV ≥ RD_LAT+2
RD_LAT, 1, ROM read latency in cycles from rom_rd/rom_addr to valid rom_data

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: begin playback
stop  in  1  one-cycle pulse: abort playback
pause  in  1  level: hold playback at the next sample boundary
start_addr  in  AW  first sample address, sampled when start is accepted
end_addr  in  AW  last sample address (inclusive), sampled when start is accepted
rom_addr  out  AW  ROM read address
rom_rd  out  1  ROM read strobe, one cycle per sample
rom_data  in  DW  ROM read data, valid RD_LAT cycles after rom_rd
sample  out  DW  current sample to the PWM stage (registered)
sample_vld  out  1  one-cycle pulse when sample updates
aud_en  out  1  PWM enable; high in RUN and PAUSE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the last sample period completes

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, addr=0, tick_cnt=0.
  - All outputs 0: rom_addr, rom_rd, sample, sample_vld, aud_en, busy, done.
- States: IDLE, RUN, PAUSE. tick_cnt counts 0..DIV-1 in RUN and is held at 0 otherwise.
- IDLE:
  - start=1 and start_addr ≤ end_addr: latch start_addr/end_addr, addr=start_addr, next state RUN with tick_cnt=0.
  - start with start_addr > end_addr: ignored; no done pulse.
- RUN:
  - At tick_cnt==0: rom_rd=1 and rom_addr=addr for exactly one cycle.
  - At tick_cnt==RD_LAT: rom_data is registered into sample, and sample_vld pulses the following cycle.
  - Latency: start accepted at cycle t → rom_rd at t+1 → sample_vld at t+2+RD_LAT.
  - Period from one sample_vld to the next is exactly DIV cycles.
- RUN at tick_cnt==DIV-1, evaluated in priority order:
  1. addr==end_addr: done pulses next cycle, state goes to IDLE, aud_en drops, sample holds its last value.
  2. Else if pause=1: addr=addr+1, state goes to PAUSE.
  3. Else: addr=addr+1, tick_cnt=0, state stays RUN.
- PAUSE:
  - No rom_rd; sample holds; aud_en stays 1.
  - When pause=0, go to RUN with tick_cnt=0, which immediately fetches the next address.
  - pause asserted mid-period takes effect only at the period boundary.
- stop:
  - In RUN or PAUSE: next state IDLE, sample cleared to 0, aud_en=0, tick_cnt=0, no done pulse.
  - stop in IDLE has no effect.
  - stop has priority over start in the same cycle.
- start while busy: ignored, including the same cycle as done.
- Address arithmetic:
  - AW-bit unsigned. Because start_addr ≤ end_addr, addr never wraps.
  - end_addr=2^AW-1 is legal and terminates on equality.
- Reset asserted mid-playback: immediate return to the reset state on that edge; any in-flight ROM read is discarded.

Optional Feature:
Macro: SOUND_PLAY_LOOP_EN
- Defined:
  - Adds input port loop_cnt [7:0], sampled when start is accepted.
  - At the end-of-range boundary with loops_left>0: decrement loops_left, addr=latched start_addr, continue in RUN with no gap (period stays DIV). aud_en stays high and done does not pulse.
  - done pulses only after loop_cnt+1 total passes. loop_cnt=0 gives a single pass.
  - stop aborts all remaining passes.
- Not defined: port is absent and playback is a single pass.

Test Plan:
All scenarios use DIV=8, RD_LAT=1, rom_data = address value.
- Basic playback: start with start_addr=4, end_addr=6 → rom_rd at t+1, t+9, t+17 with rom_addr 4, 5, 6; sample_vld at t+3, t+11, t+19 with sample 4, 5, 6; done at t+25; busy/aud_en high t+1..t+24.
- Single sample: start with start_addr=end_addr=9 → one rom_rd, sample=9, done 8 cycles after rom_rd; start with start_addr=7, end_addr=3 → no activity, busy stays 0.
- Pause: pause=1 raised mid-period of addr 5 → no rom_rd while held, sample stays 5, aud_en=1; pause=0 → rom_rd with rom_addr=6 the next cycle.
- Stop: stop during RUN at addr 5 → IDLE next cycle, sample=0, aud_en=0, no done; start+stop in the same cycle in IDLE → remains IDLE.
- Reset: rstn=0 mid-RUN → all outputs 0 next edge; start while busy is ignored (rom_addr sequence unchanged).
- SOUND_PLAY_LOOP_EN: loop_cnt=1 with range 2..3 → rom_addr sequence 2, 3, 2, 3 at 8-cycle spacing; exactly one done pulse, after the final 3.
